traffic_request_timer: RTL

TRAFFIC_REQUEST_TIMER -- requirements
Module: traffic_request_timer

---
 rtl/traffic_request_timer_if.sv | 21 ++
 rtl/traffic_request_timer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/traffic_request_timer_if.sv
// rtl/traffic_request_timer_if.sv - lamp/sensor inputs and request/timer status outputs of the request timer
interface traffic_request_timer_if;
  logic       car_raw;
  logic       grn;
  logic       ylw;
  logic       red;
  logic       CAR;
  logic       timeout;
  logic       fault;
  logic [7:0] red_count;

  modport master (
    output car_raw, grn, ylw, red,
    input  CAR, timeout, fault, red_count
  );

  modport slave (
    input  car_raw, grn, ylw, red,
    output CAR, timeout, fault, red_count
  );
endinterface

// File: rtl/traffic_request_timer.sv
// rtl/traffic_request_timer.sv - debounced vehicle request, red-phase timer and lamp-encoding fault flag
// Optional minimum-green gating of CAR is enabled by defining TRAFFIC_MIN_GREEN_EN.
module traffic_request_timer #(
  parameter int DEBOUNCE  = 3,
  parameter int RED_TICKS = 10,
  parameter int MIN_GREEN = 8
) (
  input logic                    Clock,
  input logic                    Reset,
  traffic_request_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GREEN_WAIT, RED_TIMING, EXPIRED} phase_t;

  localparam logic [3:0] DB_MAX  = 4'(DEBOUNCE);
  localparam logic [7:0] RED_PEN = 8'(RED_TICKS - 2);

  phase_t     state;
  logic       sync_q1;
  logic       sync_q2;
  logic [3:0] db_cnt;
  logic       pending;
  logic       lamp_bad;
  logic       detect;
  logic       car_ok;

  assign lamp_bad = !(({bus.grn, bus.ylw, bus.red} == 3'b100) ||
                      ({bus.grn, bus.ylw, bus.red} == 3'b010) ||
                      ({bus.grn, bus.ylw, bus.red} == 3'b001));

  // Fires once, on the edge where the count climbs to DEBOUNCE.
  assign detect = sync_q2 && (db_cnt == DB_MAX - 4'd1);

`ifdef TRAFFIC_MIN_GREEN_EN
  localparam logic [7:0] DWELL_MAX = 8'(MIN_GREEN);
  logic [7:0] dwell;

  // Held at zero outside green, so every grn rise starts a fresh dwell.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      dwell <= '0;
    end else if (lamp_bad || !bus.grn) begin
      dwell <= '0;
    end else if (dwell != DWELL_MAX) begin
      dwell <= dwell + 8'd1;
    end
  end

  assign car_ok = (dwell == DWELL_MAX);
`else
  logic unused_min_green;
  assign unused_min_green = ^MIN_GREEN;
  assign car_ok           = 1'b1;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_q1       <= 1'b0;
      sync_q2       <= 1'b0;
      db_cnt        <= '0;
      pending       <= 1'b0;
      state         <= IDLE;
      bus.CAR       <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.fault     <= 1'b0;
      bus.red_count <= '0;
    end else begin
      sync_q1   <= bus.car_raw;
      sync_q2   <= sync_q1;
      bus.fault <= lamp_bad;
      if (lamp_bad) begin
        db_cnt        <= '0;
        pending       <= 1'b0;
        state         <= IDLE;
        bus.CAR       <= 1'b0;
        bus.timeout   <= 1'b0;
        bus.red_count <= '0;
      end else begin
        if (!sync_q2) begin
          db_cnt <= '0;
        end else if (db_cnt != DB_MAX) begin
          db_cnt <= db_cnt + 4'd1;
        end
        // A detection coinciding with yellow wins, so the car is served next green.
        if (detect) begin
          pending <= 1'b1;
        end else if (bus.ylw) begin
          pending <= 1'b0;
        end
        bus.CAR <= pending && bus.grn && car_ok;
        case (state)
          IDLE: begin
            bus.timeout   <= 1'b0;
            bus.red_count <= '0;
            if (bus.grn) state <= GREEN_WAIT;
          end
          GREEN_WAIT: begin
            bus.timeout   <= 1'b0;
            bus.red_count <= '0;
            if (bus.red) state <= RED_TIMING;
          end
          RED_TIMING: begin
            if (!bus.red) begin
              state         <= GREEN_WAIT;
              bus.red_count <= '0;
            end else if (bus.red_count == RED_PEN) begin
              state         <= EXPIRED;
              bus.timeout   <= 1'b1;
              bus.red_count <= bus.red_count + 8'd1;
            end else begin
              bus.red_count <= bus.red_count + 8'd1;
            end
          end
          EXPIRED: begin
            if (!bus.red) bus.red_count <= '0;
            if (bus.grn) begin
              state       <= GREEN_WAIT;
              bus.timeout <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
